// File: rtl/uart_ctrl_pkg.sv
// Shared types and constants for the UART transmit scheduler.
package uart_ctrl_pkg;

    typedef enum logic [1:0] {
        IDLE,
        LAUNCH,
        WAIT_DONE
    } state_e;

    localparam int TIMEOUT_CYC_DEF = 1023;

    function automatic int id_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Rotating-priority pick: first set request at or after ptr, wrapping.
module rr_arbiter #(
    parameter int NUM_REQ = 4,
    parameter int ID_W    = 2
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [ID_W-1:0]    ptr,
    output logic [NUM_REQ-1:0] grant,
    output logic [ID_W-1:0]    idx,
    output logic               valid
);

    int              j;
    logic [ID_W-1:0] jj;

    always_comb begin
        grant = '0;
        idx   = '0;
        valid = 1'b0;
        j     = 0;
        jj    = '0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            jj = ID_W'(j);
            if (!valid && req[jj]) begin
                valid     = 1'b1;
                grant[jj] = 1'b1;
                idx       = jj;
            end
        end
    end

endmodule

// File: rtl/uart_tx_scheduler.sv
// Round-robin sharing of one UART transmitter among byte requesters,
// sequencing start/ready per byte and aborting stalled handshakes.
module uart_tx_scheduler
    import uart_ctrl_pkg::*;
#(
    parameter int NUM_REQ     = 4,
    parameter int DATA_W      = 8,
    parameter int TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         en,
    input  logic [NUM_REQ-1:0]           req,
    input  logic [NUM_REQ*DATA_W-1:0]    req_data,
    output logic [NUM_REQ-1:0]           ack,
    output logic [DATA_W-1:0]            data_tx,
    output logic                         start,
    input  logic                         ready,
    output logic                         busy,
    output logic                         done,
    output logic [id_width(NUM_REQ)-1:0] done_id,
    output logic                         err,
    output logic [id_width(NUM_REQ)-1:0] err_id
);

    localparam int ID_W  = id_width(NUM_REQ);
    localparam int CNT_W = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(TIMEOUT_CYC);
    localparam logic [ID_W-1:0]  LAST_ID = ID_W'(NUM_REQ - 1);

    state_e              state, state_n;
    logic [CNT_W-1:0]    cnt, cnt_n;
    logic [ID_W-1:0]     rr_ptr, rr_ptr_n;
    logic [ID_W-1:0]     owner, owner_n, owner_inc;
    logic [ID_W-1:0]     gnt_idx, done_id_n, err_id_n;
    logic [NUM_REQ-1:0]  gnt, ack_n;
    logic                gnt_valid, start_n, done_n, err_n;
    logic [DATA_W-1:0]   data_n;

    rr_arbiter #(
        .NUM_REQ(NUM_REQ),
        .ID_W   (ID_W)
    ) u_arb (
        .req  (req),
        .ptr  (rr_ptr),
        .grant(gnt),
        .idx  (gnt_idx),
        .valid(gnt_valid)
    );

    assign owner_inc = (owner == LAST_ID) ? '0 : owner + 1'b1;
    assign busy      = (state != IDLE);

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= IDLE;
            cnt     <= '0;
            rr_ptr  <= '0;
            owner   <= '0;
            ack     <= '0;
            data_tx <= '0;
            start   <= 1'b0;
            done    <= 1'b0;
            done_id <= '0;
            err     <= 1'b0;
            err_id  <= '0;
        end else begin
            state   <= state_n;
            cnt     <= cnt_n;
            rr_ptr  <= rr_ptr_n;
            owner   <= owner_n;
            ack     <= ack_n;
            data_tx <= data_n;
            start   <= start_n;
            done    <= done_n;
            done_id <= done_id_n;
            err     <= err_n;
            err_id  <= err_id_n;
        end
    end

    always_comb begin
        state_n   = state;
        cnt_n     = cnt;
        rr_ptr_n  = rr_ptr;
        owner_n   = owner;
        ack_n     = '0;
        data_n    = data_tx;
        start_n   = start;
        done_n    = 1'b0;
        done_id_n = done_id;
        err_n     = 1'b0;
        err_id_n  = err_id;
        unique case (state)
            IDLE: begin
                if (en && ready && gnt_valid) begin
                    ack_n   = gnt;
                    data_n  = req_data[gnt_idx*DATA_W +: DATA_W];
                    owner_n = gnt_idx;
                    start_n = 1'b1;
                    cnt_n   = '0;
                    state_n = LAUNCH;
                end
            end
            LAUNCH: begin
                // A falling ready wins over a timeout on the same cycle.
                if (!ready) begin
                    start_n = 1'b0;
                    cnt_n   = '0;
                    state_n = WAIT_DONE;
                end else if (cnt == CNT_MAX) begin
                    start_n  = 1'b0;
                    err_n    = 1'b1;
                    err_id_n = owner;
                    rr_ptr_n = owner_inc;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            WAIT_DONE: begin
                if (ready) begin
                    done_n    = 1'b1;
                    done_id_n = owner;
                    rr_ptr_n  = owner_inc;
                    state_n   = IDLE;
                end else if (cnt == CNT_MAX) begin
                    err_n    = 1'b1;
                    err_id_n = owner;
                    rr_ptr_n = owner_inc;
                    state_n  = IDLE;
                end else begin
                    cnt_n = cnt + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase
    end

endmodule

// File: doc/uart_tx_scheduler.md
Name: uart_tx_scheduler

Overview:
Shares the single UART transmitter (8-bit data_tx, level start, ready status) between NUM_REQ byte requesters. It uses round-robin arbitration and sequences the start/ready handshake for each byte. It sits between on-chip requesters (CPU-side peripheral write path, debug logger, DMA-style sources) and the UART core. It reports completion and handshake timeouts per requester.

Parameters:
NUM_REQ, 4, number of requesters (2..8)
DATA_W, 8, byte width driven to the UART transmitter
TIMEOUT_CYC, 1023, max cycles allowed in either handshake phase before abort (counter width = clog2(TIMEOUT_CYC+1))

Ports:
clk  in  1  system clock, all logic on rising edge
rst  in  1  synchronous, active-high reset
en  in  1  1 = new grants allowed; 0 = finish in-flight byte, then hold
req  in  NUM_REQ  per-requester byte request, held until ack
req_data  in  NUM_REQ*DATA_W  flattened bytes; requester i at [i*DATA_W +: DATA_W]
ack  out  NUM_REQ  one-hot, 1-cycle pulse: byte of requester i captured
data_tx  out  DATA_W  byte to UART transmitter, registered
start  out  1  transmit request to UART
ready  in  1  UART transmitter idle/done status
busy  out  1  high whenever state != IDLE
done  out  1  1-cycle pulse: byte fully transmitted
done_id  out  clog2(NUM_REQ)  owner of completed byte, valid with done
err  out  1  1-cycle pulse: handshake timeout
err_id  out  clog2(NUM_REQ)  owner of aborted byte, valid with err

Behaviour:
- Reset (rst=1 at edge): state IDLE; start=0, data_tx=0, ack=0, done=0, err=0, done_id=0, err_id=0; rr_ptr=0, owner=0, timeout counter=0. Reset mid-transfer drops start the next cycle. No done or err is issued for the abandoned byte.
- FSM states: IDLE, LAUNCH, WAIT_DONE. All outputs are registered.
- IDLE: grant when en=1, ready=1 and |req.
  - Winner is the first set req bit searching from rr_ptr upward, wrapping modulo NUM_REQ.
  - Next edge: data_tx<=req_data[winner], owner<=winner, ack[winner]=1 for one cycle, start<=1, counter<=0, go LAUNCH.
  - Latency: req sampled at edge t gives ack and start high in cycle t+1.
  - ready=0 in IDLE blocks grants; no error is raised.
- LAUNCH: start held 1, counter increments each cycle.
  - ready=0 seen: start<=0, counter<=0, go WAIT_DONE.
  - counter==TIMEOUT_CYC before ready falls: start<=0, err=1, err_id=owner, rr_ptr<=owner+1 mod N, go IDLE.
- WAIT_DONE: start=0, counter increments.
  - ready=1 seen: done=1, done_id=owner, rr_ptr<=owner+1 (wrap), go IDLE.
  - Timeout: same abort as LAUNCH.
- After done, the earliest next grant is the following cycle; at least one IDLE cycle separates bytes.
- Requesters:
  - Deasserting req before ack withdraws the request; no ack is issued.
  - After ack, the requester may change req_data or drop req. A req held high after ack is a new byte.
  - ack is never issued while busy; at most one ack bit is set per cycle.
- en=0 in LAUNCH or WAIT_DONE does not abort the transfer; it only blocks the next grant.
- Fairness: an asserted requester waits at most NUM_REQ-1 transfers. rr_ptr advances on both done and err.
- Simultaneous events: a new req during WAIT_DONE completion is evaluated in IDLE on the next cycle. Within IDLE, the rr_ptr rotation decides between simultaneous reqs.

Decomposition:
- Package uart_ctrl_pkg: state enum (IDLE, LAUNCH, WAIT_DONE), ID width function or constant, default TIMEOUT_CYC.
- Sub-module rr_arbiter: combinational NUM_REQ-wide rotate-priority pick from req and rr_ptr, returning a one-hot grant and encoded index. The scheduler registers the result and owns rr_ptr.

Test Plan:
- Reset then req=4'b0001, req_data[7:0]=8'hA5; model drops ready 2 cycles after start, raises it 10 cycles later -> ack=0001 at t+1, data_tx=A5, start high 2 cycles, done with done_id=0.
- req=4'b1111 held, bytes 11/22/33/44, rr_ptr=0 -> grant order 0,1,2,3,0; one done per byte; no ack while busy.
- After requester 2 completes, req=4'b0101 simultaneously -> requester 0 wins before 2 (rr_ptr=3 wraps to 0).
- ready never falls, TIMEOUT_CYC=15 -> start high for 16 cycles, then err=1, err_id=owner, back to IDLE; next request still served.
- rst asserted during WAIT_DONE -> start=0, busy=0 next cycle, no done or err; ready=0 in IDLE with req pending -> no ack until ready=1.
- en=0 during a transfer with req pending -> current byte completes with done; no ack until en=1, then ack in the following cycle.
